// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, iterative 1-bit/cycle shifts.
// Define ALU_MUL_EN to add the iterative shift-add multiply on op 11.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             car,
  output logic             of,
  output logic             zf
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   r_res;
  logic               r_car;
  logic               r_of;
  logic               r_zf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH+1:0]   w_single;
  logic               w_iter;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH:0]     w_sum;
`endif

  // Result of every op that completes in one cycle, packed as {car, of, res}.
  function automatic logic [WIDTH+1:0] f_single(input logic [WIDTH-1:0] fa,
                                                input logic [WIDTH-1:0] fb,
                                                input logic [3:0]       fop);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    sum = {(WIDTH+1){1'b0}};
    r   = {WIDTH{1'b0}};
    c   = 1'b0;
    o   = 1'b0;
    case (fop)
      4'd0: begin
        sum = {1'b0, fa} + {1'b0, fb};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        o   = (fa[MSB] == fb[MSB]) && (r[MSB] != fa[MSB]);
      end
      4'd1: begin
        sum = {1'b0, fa} + {1'b0, ~fb} + {{WIDTH{1'b0}}, 1'b1};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        o   = (fa[MSB] != fb[MSB]) && (r[MSB] != fa[MSB]);
      end
      4'd2:                r = ~fa;
      4'd3:                r = fa & fb;
      4'd4:                r = fa | fb;
      4'd5:                r = fa ^ fb;
      4'd6:                r = {{(WIDTH-1){1'b0}}, ($signed(fa) < $signed(fb))};
      4'd7:                r = {{(WIDTH-1){1'b0}}, (fa == fb)};
      4'd8, 4'd9, 4'd10:   r = fa;  // only reached for a zero shift amount
      default:             r = {WIDTH{1'b0}};
    endcase
    return {c, o, r};
  endfunction

  assign w_single = f_single(a, b, op);

  // Decide whether the accepted op needs EXEC cycles.
  always_comb begin
    w_iter = 1'b0;
    if ((op == 4'd8 || op == 4'd9 || op == 4'd10) && (b[SHW-1:0] != {SHW{1'b0}})) begin
      w_iter = 1'b1;
    end else begin
`ifdef ALU_MUL_EN
      w_iter = (op == 4'd11);
`else
      w_iter = 1'b0;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_iter ? S_EXEC : S_DONE; else w_next = S_IDLE;
      S_EXEC:  if (r_cnt == CW'(1)) w_next = S_DONE; else w_next = S_EXEC;
      S_DONE:  if (out_ready) w_next = S_IDLE; else w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // One iteration step; the low half holds the shifting value (or multiplier during MUL).
  always_comb begin
    w_prod_nxt = r_prod;
`ifdef ALU_MUL_EN
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
`endif
    case (r_op)
      4'd8:  w_prod_nxt = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-2:0], 1'b0};
      4'd9:  w_prod_nxt = {r_prod[2*WIDTH-1:WIDTH], 1'b0, r_prod[WIDTH-1:1]};
      4'd10: w_prod_nxt = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1], r_prod[WIDTH-1:1]};
`ifdef ALU_MUL_EN
      4'd11: w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
`endif
      default: w_prod_nxt = r_prod;
    endcase
  end

  // State, operand, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_op        <= 4'd0;
      r_cnt       <= {CW{1'b0}};
      r_prod      <= {(2*WIDTH){1'b0}};
      r_res       <= {WIDTH{1'b0}};
      r_car       <= 1'b0;
      r_of        <= 1'b0;
      r_zf        <= 1'b0;
`ifdef ALU_MUL_EN
      r_a         <= {WIDTH{1'b0}};
`endif
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op   <= op;
            r_cnt  <= {1'b0, b[SHW-1:0]};
            r_prod <= {{WIDTH{1'b0}}, a};
`ifdef ALU_MUL_EN
            r_a    <= a;
            if (op == 4'd11) begin
              r_cnt  <= CW'(WIDTH);
              r_prod <= {{WIDTH{1'b0}}, b};
            end
`endif
            if (!w_iter) begin
              {r_car, r_of, r_res} <= w_single;
              r_zf                 <= (w_single[WIDTH-1:0] == {WIDTH{1'b0}});
            end
          end
        end
        S_EXEC: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res <= w_prod_nxt[WIDTH-1:0];
            r_zf  <= (w_prod_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
            r_of  <= 1'b0;
`ifdef ALU_MUL_EN
            r_car <= (r_op == 4'd11) ? (|w_prod_nxt[2*WIDTH-1:WIDTH]) : 1'b0;
`else
            r_car <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign car       = r_car;
  assign of        = r_of;
  assign zf        = r_zf;

endmodule
